// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS control sequencer: fetch/decode/execute/memory/writeback FSM
// with memory request handshake, timeout trap and retired-instruction counter.
module mips_mc_ctrl #(
   parameter int CNT_W       = 16,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [5:0]       opcode,
   input  logic [5:0]       funct,
   input  logic             alu_zero,
   input  logic             mem_ready,
   output logic             mem_req,
   output logic             mem_we,
   output logic             mem_sel,
   output logic             ir_write,
   output logic             pc_write,
   output logic [1:0]       pc_src,
   output logic             reg_dst,
   output logic             reg_write,
   output logic             mem_to_reg,
   output logic             alu_src,
   output logic [3:0]       alu_ctrl,
   output logic [3:0]       state,
   output logic [1:0]       trap,
   output logic [CNT_W-1:0] instr_count
);

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      EXEC_R   = 4'd2,
      EXEC_I   = 4'd3,
      WB_ALU   = 4'd4,
      MEM_ADDR = 4'd5,
      MEM_RD   = 4'd6,
      MEM_WR   = 4'd7,
      WB_MEM   = 4'd8,
      BRANCH   = 4'd9,
      JUMP     = 4'd10,
      TRAP     = 4'd15
   } state_t;

   localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);
   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;
   localparam logic [5:0] OP_R    = 6'h00;
   localparam logic [5:0] OP_LW   = 6'h23;
   localparam logic [5:0] OP_SW   = 6'h2B;
   localparam logic [5:0] OP_BEQ  = 6'h04;
   localparam logic [5:0] OP_ADDI = 6'h08;
   localparam logic [5:0] OP_J    = 6'h02;

   state_t           stateReg, stateNext;
   logic [1:0]       trapReg, trapNext;
   logic [7:0]       waitReg, waitNext;
   logic [CNT_W-1:0] countReg;
   logic             retire;

   logic memReq, memWe, irWrite, pcWrite, regWrite;
   logic [3:0] rAlu;
   logic       rLegal;

   always_comb begin
      rAlu   = ALU_ADD;
      rLegal = 1'b1;
      case (funct)
         6'h20, 6'h21: rAlu = ALU_ADD;
         6'h22:        rAlu = ALU_SUB;
         6'h24:        rAlu = ALU_AND;
         6'h25:        rAlu = ALU_OR;
         6'h2A:        rAlu = ALU_SLT;
         default:      rLegal = 1'b0;
      endcase
   end

   always_comb begin
      stateNext  = stateReg;
      trapNext   = trapReg;
      waitNext   = '0;
      retire     = 1'b0;
      memReq     = 1'b0;
      memWe      = 1'b0;
      mem_sel    = 1'b0;
      irWrite    = 1'b0;
      pcWrite    = 1'b0;
      pc_src     = 2'd0;
      reg_dst    = 1'b0;
      regWrite   = 1'b0;
      mem_to_reg = 1'b0;
      alu_src    = 1'b0;
      alu_ctrl   = ALU_ADD;
      case (stateReg)
         FETCH: begin
            memReq = 1'b1;
            if (mem_ready) begin
               irWrite   = 1'b1;
               pcWrite   = 1'b1;
               stateNext = DECODE;
            end
         end
         DECODE: begin
            case (opcode)
               OP_R:    stateNext = rLegal ? EXEC_R : TRAP;
               OP_ADDI: stateNext = EXEC_I;
               OP_LW,
               OP_SW:   stateNext = MEM_ADDR;
               OP_BEQ:  stateNext = BRANCH;
               OP_J:    stateNext = JUMP;
               default: stateNext = TRAP;
            endcase
            if (stateNext == TRAP) trapNext = 2'd1;
         end
         EXEC_R: begin
            alu_ctrl  = rAlu;
            stateNext = WB_ALU;
         end
         EXEC_I: begin
            alu_src   = 1'b1;
            stateNext = WB_ALU;
         end
         WB_ALU: begin
            regWrite  = 1'b1;
            reg_dst   = (opcode == OP_R);
            retire    = 1'b1;
            stateNext = FETCH;
         end
         MEM_ADDR: begin
            alu_src   = 1'b1;
            stateNext = (opcode == OP_LW) ? MEM_RD : MEM_WR;
         end
         MEM_RD: begin
            memReq  = 1'b1;
            mem_sel = 1'b1;
            if (mem_ready) stateNext = WB_MEM;
         end
         MEM_WR: begin
            memReq  = 1'b1;
            mem_sel = 1'b1;
            memWe   = 1'b1;
            if (mem_ready) begin
               retire    = 1'b1;
               stateNext = FETCH;
            end
         end
         WB_MEM: begin
            regWrite   = 1'b1;
            mem_to_reg = 1'b1;
            retire     = 1'b1;
            stateNext  = FETCH;
         end
         BRANCH: begin
            alu_ctrl = ALU_SUB;
            if (alu_zero) begin
               pcWrite = 1'b1;
               pc_src  = 2'd1;
            end
            retire    = 1'b1;
            stateNext = FETCH;
         end
         JUMP: begin
            pcWrite   = 1'b1;
            pc_src    = 2'd2;
            retire    = 1'b1;
            stateNext = FETCH;
         end
         TRAP:    stateNext = TRAP;
         default: stateNext = FETCH;
      endcase
      // Ready on the same cycle the counter hits the limit still wins.
      if (memReq && !mem_ready) begin
         if (waitReg == TIMEOUT) begin
            stateNext = TRAP;
            trapNext  = 2'd2;
         end else begin
            waitNext = waitReg + 8'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stateReg <= FETCH;
         trapReg  <= 2'd0;
         waitReg  <= 8'd0;
         countReg <= '0;
      end else begin
         stateReg <= stateNext;
         trapReg  <= trapNext;
         waitReg  <= waitNext;
         if (retire) countReg <= countReg + CNT_W'(1);
      end
   end

   // Strobes are gated by rst_n so a reset mid-access drops them at once.
   assign mem_req     = memReq & rst_n;
   assign mem_we      = memWe & rst_n;
   assign ir_write    = irWrite & rst_n;
   assign pc_write    = pcWrite & rst_n;
   assign reg_write   = regWrite & rst_n;
   assign state       = stateReg;
   assign trap        = trapReg;
   assign instr_count = countReg;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Cycle-by-cycle scoreboard bench for mips_mc_ctrl using directed instruction
// sequences with hand-written expected control vectors.
module tb_mips_mc_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [5:0]  opcode, funct;
   logic        alu_zero, mem_ready;
   logic        mem_req, mem_we, mem_sel, ir_write, pc_write;
   logic [1:0]  pc_src;
   logic        reg_dst, reg_write, mem_to_reg, alu_src;
   logic [3:0]  alu_ctrl, state;
   logic [1:0]  trap;
   logic [15:0] instr_count;

   mips_mc_ctrl #(.CNT_W(16), .MEM_TIMEOUT(15)) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
      .alu_zero(alu_zero), .mem_ready(mem_ready), .mem_req(mem_req),
      .mem_we(mem_we), .mem_sel(mem_sel), .ir_write(ir_write),
      .pc_write(pc_write), .pc_src(pc_src), .reg_dst(reg_dst),
      .reg_write(reg_write), .mem_to_reg(mem_to_reg), .alu_src(alu_src),
      .alu_ctrl(alu_ctrl), .state(state), .trap(trap), .instr_count(instr_count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0]  st;
      logic [14:0] ctl;
      logic [1:0]  tr;
      logic [15:0] cnt;
   } exp_t;

   // ctl = {mem_req, mem_we, mem_sel, ir_write, pc_write, pc_src, reg_dst, reg_write, mem_to_reg, alu_src, alu_ctrl}
   localparam logic [14:0] K_IDLE  = {5'b00000, 2'd0, 4'b0000, 4'b0010};
   localparam logic [14:0] K_FWAIT = {5'b10000, 2'd0, 4'b0000, 4'b0010};
   localparam logic [14:0] K_FDONE = {5'b10011, 2'd0, 4'b0000, 4'b0010};
   localparam logic [14:0] K_EXI   = {5'b00000, 2'd0, 4'b0001, 4'b0010};
   localparam logic [14:0] K_WBR   = {5'b00000, 2'd0, 4'b1100, 4'b0010};
   localparam logic [14:0] K_WBI   = {5'b00000, 2'd0, 4'b0100, 4'b0010};
   localparam logic [14:0] K_MRD   = {5'b10100, 2'd0, 4'b0000, 4'b0010};
   localparam logic [14:0] K_MWR   = {5'b11100, 2'd0, 4'b0000, 4'b0010};
   localparam logic [14:0] K_WBM   = {5'b00000, 2'd0, 4'b0110, 4'b0010};
   localparam logic [14:0] K_BRT   = {5'b00001, 2'd1, 4'b0000, 4'b0110};
   localparam logic [14:0] K_BRN   = {5'b00000, 2'd0, 4'b0000, 4'b0110};
   localparam logic [14:0] K_JMP   = {5'b00001, 2'd2, 4'b0000, 4'b0010};

   exp_t q[$];
   int   total = 0;
   int   bad   = 0;
   int   nRet  = 0;
   logic [5:0] curOp = 6'h00;
   logic [5:0] curFn = 6'h20;

   function automatic exp_t mk(input logic [3:0] st, input logic [14:0] ctl,
                               input logic [1:0] tr, input int n);
      exp_t e;
      e.st  = st;
      e.ctl = ctl;
      e.tr  = tr;
      e.cnt = 16'(n);
      return e;
   endfunction

   // Monitor: one comparison per queued cycle, sampled mid-cycle.
   exp_t monE, monA;
   always @(negedge clk) begin
      if (q.size() > 0) begin
         monE = q.pop_front();
         monA.st  = state;
         monA.ctl = {mem_req, mem_we, mem_sel, ir_write, pc_write, pc_src,
                     reg_dst, reg_write, mem_to_reg, alu_src, alu_ctrl};
         monA.tr  = trap;
         monA.cnt = instr_count;
         total++;
         if (monA !== monE) begin
            bad++;
            $display("FAIL cycle%0d: got st=%0d ctl=%h trap=%0d cnt=%0d, need st=%0d ctl=%h trap=%0d cnt=%0d",
                     total, monA.st, monA.ctl, monA.tr, monA.cnt,
                     monE.st, monE.ctl, monE.tr, monE.cnt);
         end else begin
            $display("chk %0d st=%0d ctl=%h trap=%0d cnt=%0d ok",
                     total, monA.st, monA.ctl, monA.tr, monA.cnt);
         end
      end
   end

   task automatic cyc(input logic r, input logic rdy, input logic z, input exp_t e);
      @(posedge clk);
      #1;
      rst_n     = r;
      mem_ready = rdy;
      alu_zero  = z;
      opcode    = curOp;
      funct     = curFn;
      q.push_back(e);
   endtask

   task automatic fetch1();
      cyc(1'b1, 1'b1, 1'b0, mk(4'd0, K_FDONE, 2'd0, nRet));
   endtask

   task automatic decode(input logic rdy);
      cyc(1'b1, rdy, 1'b0, mk(4'd1, K_IDLE, 2'd0, nRet));
   endtask

   task automatic doReset();
      cyc(1'b0, 1'b0, 1'b0, mk(4'd0, K_IDLE, 2'd0, 0));
      nRet = 0;
   endtask

   task automatic instR(input logic [5:0] fn, input logic [3:0] alu);
      curOp = 6'h00; curFn = fn;
      fetch1(); decode(1'b0);
      cyc(1'b1, 1'b0, 1'b0, mk(4'd2, {5'b00000, 2'd0, 4'b0000, alu}, 2'd0, nRet));
      cyc(1'b1, 1'b0, 1'b0, mk(4'd4, K_WBR, 2'd0, nRet));
      nRet++;
   endtask

   task automatic instAddi();
      curOp = 6'h08; curFn = 6'h00;
      fetch1(); decode(1'b0);
      cyc(1'b1, 1'b0, 1'b0, mk(4'd3, K_EXI, 2'd0, nRet));
      cyc(1'b1, 1'b0, 1'b0, mk(4'd4, K_WBI, 2'd0, nRet));
      nRet++;
   endtask

   task automatic instJ();
      curOp = 6'h02; curFn = 6'h00;
      fetch1(); decode(1'b1);
      cyc(1'b1, 1'b0, 1'b0, mk(4'd10, K_JMP, 2'd0, nRet));
      nRet++;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, total=%0d", total);
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; mem_ready = 1'b0; alu_zero = 1'b0;
      opcode = 6'h00; funct = 6'h20;
      doReset(); doReset();

      // R-type add, single-cycle fetch.
      instR(6'h20, 4'b0010);

      // lw with three wait cycles in MEM_RD.
      curOp = 6'h23; curFn = 6'h00;
      fetch1(); decode(1'b0);
      cyc(1'b1, 1'b0, 1'b0, mk(4'd5, K_EXI, 2'd0, nRet));
      for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, mk(4'd6, K_MRD, 2'd0, nRet));
      cyc(1'b1, 1'b1, 1'b0, mk(4'd6, K_MRD, 2'd0, nRet));
      cyc(1'b1, 1'b0, 1'b0, mk(4'd8, K_WBM, 2'd0, nRet));
      nRet++;

      // beq taken, then not taken; stray mem_ready in DECODE is ignored.
      curOp = 6'h04;
      fetch1(); decode(1'b1);
      cyc(1'b1, 1'b0, 1'b1, mk(4'd9, K_BRT, 2'd0, nRet));
      nRet++;
      fetch1(); decode(1'b0);
      cyc(1'b1, 1'b0, 1'b0, mk(4'd9, K_BRN, 2'd0, nRet));
      nRet++;

      // sw completing in its first request cycle.
      curOp = 6'h2B;
      fetch1(); decode(1'b0);
      cyc(1'b1, 1'b0, 1'b0, mk(4'd5, K_EXI, 2'd0, nRet));
      cyc(1'b1, 1'b1, 1'b0, mk(4'd7, K_MWR, 2'd0, nRet));
      nRet++;

      instJ();
      instAddi();
      instR(6'h21, 4'b0010);
      instR(6'h22, 4'b0110);
      instR(6'h24, 4'b0000);
      instR(6'h25, 4'b0001);
      instR(6'h2A, 4'b0111);

      // Fetch ready arrives exactly when the wait counter hits the limit.
      curOp = 6'h02; curFn = 6'h00;
      for (int i = 0; i < 15; i++) cyc(1'b1, 1'b0, 1'b0, mk(4'd0, K_FWAIT, 2'd0, nRet));
      fetch1(); decode(1'b0);
      cyc(1'b1, 1'b0, 1'b0, mk(4'd10, K_JMP, 2'd0, nRet));
      nRet++;

      // Fetch never completes: bus timeout trap.
      for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 1'b0, mk(4'd0, K_FWAIT, 2'd0, nRet));
      for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b0, mk(4'd15, K_IDLE, 2'd2, nRet));

      // Illegal opcode: sticky trap with no memory requests.
      doReset();
      curOp = 6'h3F; curFn = 6'h00;
      fetch1(); decode(1'b0);
      for (int i = 0; i < 20; i++) cyc(1'b1, 1'(i % 2), 1'b0, mk(4'd15, K_IDLE, 2'd1, nRet));

      // Unsupported R-type funct is illegal too.
      doReset();
      curOp = 6'h00; curFn = 6'h3F;
      fetch1(); decode(1'b0);
      for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, mk(4'd15, K_IDLE, 2'd1, nRet));

      // Reset asserted during a waiting sw: strobes drop, no retire.
      doReset();
      instAddi();
      curOp = 6'h2B; curFn = 6'h00;
      fetch1(); decode(1'b0);
      cyc(1'b1, 1'b0, 1'b0, mk(4'd5, K_EXI, 2'd0, nRet));
      cyc(1'b1, 1'b0, 1'b0, mk(4'd7, K_MWR, 2'd0, nRet));
      cyc(1'b1, 1'b0, 1'b0, mk(4'd7, K_MWR, 2'd0, nRet));
      cyc(1'b0, 1'b1, 1'b0, mk(4'd0, K_IDLE, 2'd0, 0));
      nRet = 0;
      doReset();
      instJ();
      cyc(1'b1, 1'b0, 1'b0, mk(4'd0, K_FWAIT, 2'd0, nRet));

      @(negedge clk);
      #1;
      total++;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL drain: got %0d pending entries, need 0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
